// File: rtl/jtdsp16_pkg.sv
// jtdsp16_pkg: shared jtdsp16 constants and program loader state encoding.
package jtdsp16_pkg;
    localparam int JTDSP16_AW       = 12;
    localparam int JTDSP16_PROG_LEN = 512;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_RUN   = 3'd4;
    localparam logic [2:0] ST_ERROR = 3'd5;
endpackage

// File: rtl/jtdsp16_ldr_csum.sv
// jtdsp16_ldr_csum: 16-bit running sum of loaded words, compared against a trailing check word.
module jtdsp16_ldr_csum (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        clr,
    input  logic        add,
    input  logic [15:0] din,
    output logic        ok
);
    logic [15:0] sum;

    always_ff @(posedge clk) begin
        if (rst) sum <= '0;
        else if (cen) sum <= clr ? 16'd0 : add ? sum + din : sum;
    end

    assign ok = sum == din;
endmodule

// File: rtl/jtdsp16_prog_loader.sv
// jtdsp16_prog_loader: streams LEN words into jtdsp16 program RAM, then releases core reset.
// Define JTDSP16_LOADER_CHECKSUM_EN to verify a trailing checksum word before release.
module jtdsp16_prog_loader
    import jtdsp16_pkg::*;
#(
    parameter int AW       = JTDSP16_AW,
    parameter int LEN      = JTDSP16_PROG_LEN,
    parameter int RST_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          start,
    input  logic [15:0]   dl_data,
    input  logic          dl_valid,
    output logic          dl_ready,
    output logic [AW-1:0] prog_addr,
    output logic [15:0]   prog_data,
    output logic          prog_we,
    output logic          core_rst,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int HW = RST_HOLD > 1 ? $clog2(RST_HOLD) : 1;
    localparam logic [AW:0]   CNT_LAST  = (AW+1)'(LEN - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

    logic [2:0]    st;
    logic [AW:0]   cnt;
    logic [HW-1:0] hcnt;
    logic          rdy_r, we_r, acc, last, go;

    // Strobes are held in registers across cen=0 cycles and only shown when cen is high
    assign dl_ready = rdy_r & cen;
    assign prog_we  = we_r & cen;
    assign acc      = dl_valid & dl_ready;
    assign last     = cnt == CNT_LAST;
    assign go       = start && (st == ST_IDLE || st == ST_RUN || st == ST_ERROR);

`ifdef JTDSP16_LOADER_CHECKSUM_EN
    localparam logic [2:0] ST_AFTER = ST_CHECK;
    logic err_r, csum_ok;

    jtdsp16_ldr_csum u_csum (
        .clk  (clk),
        .rst  (rst),
        .cen  (cen),
        .clr  (go),
        .add  (acc && st == ST_LOAD),
        .din  (dl_data),
        .ok   (csum_ok)
    );

    assign err = err_r;
`else
    localparam logic [2:0] ST_AFTER = ST_HOLD;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= ST_IDLE;
            cnt       <= '0;
            hcnt      <= '0;
            rdy_r     <= 1'b0;
            we_r      <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
            core_rst  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef JTDSP16_LOADER_CHECKSUM_EN
            err_r     <= 1'b0;
`endif
        end else if (cen) begin
            we_r <= 1'b0;
            case (st)
                ST_LOAD: if (acc) begin
                    we_r      <= 1'b1;
                    prog_addr <= cnt[AW-1:0];
                    prog_data <= dl_data;
                    cnt       <= cnt + 1'b1;
                    if (last) begin
                        st    <= ST_AFTER;
                        rdy_r <= ST_AFTER == ST_CHECK;
                        hcnt  <= '0;
                    end
                end
`ifdef JTDSP16_LOADER_CHECKSUM_EN
                ST_CHECK: if (acc) begin
                    rdy_r <= 1'b0;
                    st    <= csum_ok ? ST_HOLD : ST_ERROR;
                    err_r <= !csum_ok;
                    busy  <= csum_ok;
                end
`endif
                ST_HOLD: begin
                    hcnt <= hcnt + 1'b1;
                    if (hcnt == HOLD_LAST) begin
                        st       <= ST_RUN;
                        core_rst <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                default: if (go) begin
                    st       <= ST_LOAD;
                    cnt      <= '0;
                    rdy_r    <= 1'b1;
                    core_rst <= 1'b1;
                    busy     <= 1'b1;
                    done     <= 1'b0;
`ifdef JTDSP16_LOADER_CHECKSUM_EN
                    err_r    <= 1'b0;
`endif
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jtdsp16_prog_loader.sv
// tb_jtdsp16_prog_loader: directed bench for the program loader with LEN=4, RST_HOLD=2.
module tb_jtdsp16_prog_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1, cen = 1'b1, start = 1'b0, dl_valid = 1'b0;
    logic [15:0] dl_data = '0;
    logic        dl_ready, prog_we, core_rst, busy, done, err;
    logic [11:0] prog_addr;
    logic [15:0] prog_data;

    int errs = 0, checks = 0, cyc_n = 0, bad_we = 0;
    logic [15:0] words [5];
    logic [11:0] wa[$];
    logic [15:0] wd[$];
    int          wc[$];

    jtdsp16_prog_loader #(.AW(12), .LEN(4), .RST_HOLD(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .start     (start),
        .dl_data   (dl_data),
        .dl_valid  (dl_valid),
        .dl_ready  (dl_ready),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_we   (prog_we),
        .core_rst  (core_rst),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n++;

    always @(negedge clk) begin
        if (prog_we) begin
            wa.push_back(prog_addr);
            wd.push_back(prog_data);
            wc.push_back(cyc_n);
            if (!cen) bad_we++;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
        bad_we = 0;
    endtask

    // Source holds the current word until it is seen accepted at the negedge
    task automatic run_stream(input int n, input bit toggle);
        int idx = 0;
        int cyc = 0;
        while (idx < n && cyc < 60) begin
            cen      = toggle ? (cyc % 3 != 2) : 1'b1;
            dl_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            dl_data  = words[idx];
            @(negedge clk);
            if (dl_valid && dl_ready) idx++;
            step();
            cyc++;
        end
        dl_valid = 1'b0;
        cen      = 1'b1;
        chk("stream_words", idx, n);
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_count"}, wa.size(), 4);
        chk({tag, "_bad_we"}, bad_we, 0);
        for (int i = 0; i < 4 && i < wa.size(); i++) begin
            chk({tag, "_addr"}, wa[i], i);
            chk({tag, "_data"}, wd[i], words[i]);
        end
    endtask

    initial begin
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
        words[4] = 16'h5555;
        repeat (3) step();
        @(negedge clk);
        chk("rst_core_rst", core_rst, 1);
        chk("rst_ready", dl_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", prog_we, 0);
        chk("rst_err", err, 0);
        step();
        rst = 1'b0;

        // Continuous stream
        clear_log();
        pulse_start();
        @(negedge clk);
        chk("t1_busy", busy, 1);
        chk("t1_ready", dl_ready, 1);
        step();
        run_stream(4, 1'b0);
`ifndef JTDSP16_LOADER_CHECKSUM_EN
        @(negedge clk);
        chk("t1_last_we", prog_we, 1);
        chk("t1_last_addr", prog_addr, 3);
        chk("t1_ready_drop", dl_ready, 0);
        chk("t1_hold_rst0", core_rst, 1);
        @(negedge clk);
        chk("t1_hold_we", prog_we, 0);
        chk("t1_hold_rst1", core_rst, 1);
        @(negedge clk);
        chk("t1_release", core_rst, 0);
        chk("t1_done", done, 1);
        chk("t1_busy_run", busy, 0);
        check_writes("t1");
        if (wc.size() == 4) chk("t1_consecutive", wc[3] - wc[0], 3);

        // Gapped valid and cen, started from RUN
        clear_log();
        pulse_start();
        @(negedge clk);
        chk("t2_rst_again", core_rst, 1);
        chk("t2_done_clr", done, 0);
        step();
        run_stream(4, 1'b1);
        repeat (4) step();
        @(negedge clk);
        chk("t2_done", done, 1);
        check_writes("t2");

        // Reset in the middle of a download
        pulse_start();
        run_stream(2, 1'b0);
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("t3_we", prog_we, 0);
        chk("t3_core_rst", core_rst, 1);
        chk("t3_busy", busy, 0);
        chk("t3_ready", dl_ready, 0);
        step();
        start = 1'b1;
        step();
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("t3_rst_wins", busy, 0);
        step();
        clear_log();
        pulse_start();
        run_stream(4, 1'b0);
        repeat (4) step();
        check_writes("t3");

        // A fifth word must not be consumed
        pulse_start();
        run_stream(4, 1'b0);
        begin
            int extra = 0;
            dl_valid = 1'b1;
            dl_data  = 16'h5555;
            repeat (4) begin
                @(negedge clk);
                if (dl_valid && dl_ready) extra++;
                step();
            end
            dl_valid = 1'b0;
            chk("t4_no_extra", extra, 0);
        end
        @(negedge clk);
        chk("t4_done", done, 1);
        chk("t4_err", err, 0);
`else
        words[0] = 16'd1; words[1] = 16'd2; words[2] = 16'd3; words[3] = 16'd4;
        words[4] = 16'h000A;
        clear_log();
        pulse_start();
        run_stream(5, 1'b0);
        repeat (3) @(negedge clk);
        chk("cs_ok_done", done, 1);
        chk("cs_ok_rst", core_rst, 0);
        chk("cs_ok_err", err, 0);
        check_writes("cs_ok");
        words[4] = 16'h000B;
        pulse_start();
        run_stream(5, 1'b0);
        @(negedge clk);
        chk("cs_bad_err", err, 1);
        chk("cs_bad_rst", core_rst, 1);
        chk("cs_bad_busy", busy, 0);
        chk("cs_bad_done", done, 0);
        step();
        pulse_start();
        @(negedge clk);
        chk("cs_clr_err", err, 0);
        chk("cs_clr_busy", busy, 1);
        step();
        words[4] = 16'h000A;
        run_stream(5, 1'b0);
        repeat (3) @(negedge clk);
        chk("cs_reload_done", done, 1);
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
